// File: rtl/fx_pkg.sv
// Shared types and helpers for the crossfading path selector.
package fx_pkg;

  // Fade controller state: passing one path through, or blending two paths.
  typedef enum logic {
    FX_IDLE = 1'b0,
    FX_FADE = 1'b1
  } fx_state_e;

  // Width of one weighted product: a signed sample times an unsigned
  // (ramp_log2+1)-bit weight that has been zero-extended to signed.
  function automatic int fx_prod_width(input int data_width, input int ramp_log2);
    return data_width + ramp_log2 + 2;
  endfunction

endpackage

// File: rtl/fx_blend.sv
// Two-stage pipelined weighted sum: out = (a*wa + b*wb) >>> RAMP_LOG2.
// Stage 1 registers both products with the valid bit; stage 2 registers the
// shifted sum. The output holds between valids; out_valid is a pulse.
module fx_blend
  import fx_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int RAMP_LOG2  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  input  logic        [RAMP_LOG2:0]    wa,
  input  logic        [RAMP_LOG2:0]    wb,
  output logic signed [DATA_WIDTH-1:0] out,
  output logic                         out_valid
);

  localparam int PW = fx_prod_width(DATA_WIDTH, RAMP_LOG2);

  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;
  logic signed [PW-1:0] wa_ext;
  logic signed [PW-1:0] wb_ext;
  logic signed [PW-1:0] prod_a;
  logic signed [PW-1:0] prod_b;
  logic                 prod_valid;
  logic signed [PW:0]   sum;

  // Samples are sign-extended, weights zero-extended, so both multiplies are
  // plain signed products at full width with no overflow.
  assign a_ext  = {{(PW-DATA_WIDTH){a[DATA_WIDTH-1]}}, a};
  assign b_ext  = {{(PW-DATA_WIDTH){b[DATA_WIDTH-1]}}, b};
  assign wa_ext = {{(PW-RAMP_LOG2-1){1'b0}}, wa};
  assign wb_ext = {{(PW-RAMP_LOG2-1){1'b0}}, wb};

  // Stage 1: capture both weighted products on a valid sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_a     <= '0;
      prod_b     <= '0;
      prod_valid <= 1'b0;
    end else begin
      prod_valid <= in_valid;
      if (in_valid) begin
        prod_a <= a_ext * wa_ext;
        prod_b <= b_ext * wb_ext;
      end
    end
  end

  // One extra bit so the sum of two full-width products cannot wrap.
  assign sum = {prod_a[PW-1], prod_a} + {prod_b[PW-1], prod_b};

  // Stage 2: floor-shift the sum back to sample scale. Weights sum to
  // 2^RAMP_LOG2, so the result always fits DATA_WIDTH without saturation.
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= prod_valid;
      if (prod_valid) begin
        out <= DATA_WIDTH'(sum >>> RAMP_LOG2);
      end
    end
  end

endmodule

// File: rtl/fx_crossfade_mux.sv
// N-way audio path selector with click-free linear crossfade on a selection
// change. All paths share one valid strobe and are latency-aligned.
//
// Handshake: there is no backpressure. sample_valid is a one-cycle strobe
// qualifying every lane of audio_in in that cycle; audio_out_valid is a
// one-cycle strobe exactly two cycles later, and audio_out holds in between.
//
// The fade FSM state is observable on busy (high exactly in FX_FADE).
module fx_crossfade_mux
  import fx_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_PATHS  = 4,
  parameter  int RAMP_LOG2  = 8,
  localparam int SEL_WIDTH  = $clog2(NUM_PATHS)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 sample_valid,
  input  logic signed [NUM_PATHS-1:0][DATA_WIDTH-1:0] audio_in,
  input  logic        [SEL_WIDTH-1:0]          path_sel,
  output logic signed [DATA_WIDTH-1:0]         audio_out,
  output logic                                 audio_out_valid,
  output logic                                 busy
);

  localparam logic [RAMP_LOG2:0] W_FULL = {1'b1, {RAMP_LOG2{1'b0}}};

  fx_state_e            state;
  fx_state_e            state_nxt;
  logic [SEL_WIDTH-1:0] cur_sel;
  logic [SEL_WIDTH-1:0] cur_nxt;
  logic [SEL_WIDTH-1:0] tgt_sel;
  logic [SEL_WIDTH-1:0] tgt_nxt;
  logic [RAMP_LOG2-1:0] ramp;
  logic [RAMP_LOG2-1:0] ramp_nxt;
  logic [RAMP_LOG2:0]   w_tgt;
  logic [RAMP_LOG2:0]   w_cur;
  logic                 req;

  // A request is a different, in-range path; out-of-range selects are ignored.
  assign req = (path_sel != cur_sel) && (32'(path_sel) < 32'(NUM_PATHS));

  // State register for the fade controller.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FX_IDLE;
      cur_sel <= '0;
      tgt_sel <= '0;
      ramp    <= '0;
    end else begin
      state   <= state_nxt;
      cur_sel <= cur_nxt;
      tgt_sel <= tgt_nxt;
      ramp    <= ramp_nxt;
    end
  end

  // Next-state and blend weight. In IDLE the target weight is zero, so the
  // same blend datapath passes cur_sel through and latency never changes.
  // A request seen in the same cycle as a valid sample only takes effect
  // from the following sample.
  always_comb begin
    state_nxt = state;
    cur_nxt   = cur_sel;
    tgt_nxt   = tgt_sel;
    ramp_nxt  = ramp;
    w_tgt     = '0;
    case (state)
      FX_IDLE: begin
        if (req) begin
          tgt_nxt   = path_sel;
          ramp_nxt  = RAMP_LOG2'(1);
          state_nxt = FX_FADE;
        end
      end
      FX_FADE: begin
        w_tgt = {1'b0, ramp};
        if (sample_valid) begin
          ramp_nxt = ramp + RAMP_LOG2'(1);
          if (ramp == '1) begin
            cur_nxt   = tgt_sel;
            ramp_nxt  = '0;
            state_nxt = FX_IDLE;
          end
        end
      end
      default: begin
        state_nxt = FX_IDLE;
      end
    endcase
  end

  assign w_cur = W_FULL - w_tgt;
  assign busy  = (state == FX_FADE);

  fx_blend #(
    .DATA_WIDTH(DATA_WIDTH),
    .RAMP_LOG2 (RAMP_LOG2)
  ) u_blend (
    .clk      (clk),
    .rst      (rst),
    .in_valid (sample_valid),
    .a        (audio_in[cur_sel]),
    .b        (audio_in[tgt_sel]),
    .wa       (w_cur),
    .wb       (w_tgt),
    .out      (audio_out),
    .out_valid(audio_out_valid)
  );

endmodule
